// File: rtl/captura_resultado_somador.sv
// captura_resultado_somador
//
// Captures each finished result of the four-operand accumulator into a small
// show-ahead FIFO. A result is taken on every rising edge of the accumulator's
// level `pronto` flag. Results arriving while the buffer is full are dropped
// and counted in a saturating discard counter.
//
// Build option:
//   CAPTURA_SATURA_EN - when defined, a result flagged with `overflow` is
//                       stored as the saturated extreme (+31 or -32) instead of
//                       the wrapped value. The overflow flag is stored as 1 either way.
//
// Parameters:
//   PROFUNDIDADE - FIFO depth in entries (power of two, 2..16)
//   LARG_CONT    - width of the discard counter
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   pronto     in   accumulator done flag (level, idle high)
//   soma       in   accumulator result, two's complement
//   overflow   in   accumulator signed-overflow flag, valid with soma
//   rd_en      in   pop request for the head entry
//   resultado  out  head entry value, 0 when empty
//   ovf_out    out  head entry overflow flag, 0 when empty
//   valido     out  head entry present
//   vazio      out  FIFO empty
//   cheio      out  FIFO full
//   contagem   out  number of stored entries
//   descartes  out  results lost to a full FIFO, saturating

module captura_resultado_somador #(
  parameter int unsigned PROFUNDIDADE = 4,
  parameter int unsigned LARG_CONT    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pronto,
  input  logic [5:0]                      soma,
  input  logic                            overflow,
  input  logic                            rd_en,
  output logic [5:0]                      resultado,
  output logic                            ovf_out,
  output logic                            valido,
  output logic                            vazio,
  output logic                            cheio,
  output logic [$clog2(PROFUNDIDADE):0]   contagem,
  output logic [LARG_CONT-1:0]            descartes
);

  localparam int unsigned LargPtr  = $clog2(PROFUNDIDADE);
  localparam int unsigned LargCont = LargPtr + 1;

  logic                 r_pronto_d;
  logic [LargPtr-1:0]   r_ptr_esc;
  logic [LargPtr-1:0]   r_ptr_lei;
  logic [LargCont-1:0]  r_contagem;
  logic [LARG_CONT-1:0] r_descartes;
  logic [6:0]           r_mem [PROFUNDIDADE];

  logic                 w_cap;
  logic                 w_pop;
  logic                 w_vazio;
  logic                 w_cheio;
  logic                 w_escreve;
  logic                 w_descarta;
  logic [5:0]           w_valor;
  logic [6:0]           w_cabeca;

  assign w_vazio = (r_contagem == '0);
  assign w_cheio = (r_contagem == LargCont'(PROFUNDIDADE));

  // Rising edge of the level done flag; r_pronto_d resets high so the idle-high
  // flag seen right after reset is not mistaken for a new result.
  assign w_cap = pronto & ~r_pronto_d;

  // A pop while empty is ignored, so a simultaneous capture into an empty FIFO
  // is stored without bypass.
  assign w_pop = rd_en & ~w_vazio;

  // When full, a same-cycle pop frees the slot the capture needs.
  assign w_escreve  = w_cap & (~w_cheio | w_pop);
  assign w_descarta = w_cap & w_cheio & ~w_pop;

`ifdef CAPTURA_SATURA_EN
  // Wrapped-negative result (sign bit set) means the true sum was too large.
  always_comb begin
    w_valor = soma;
    if (overflow) begin
      w_valor = soma[5] ? 6'b011111 : 6'b100000;
    end
  end
`else
  assign w_valor = soma;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pronto_d  <= 1'b1;
      r_ptr_esc   <= '0;
      r_ptr_lei   <= '0;
      r_contagem  <= '0;
      r_descartes <= '0;
    end else begin
      r_pronto_d <= pronto;
      if (w_escreve) begin
        r_ptr_esc <= r_ptr_esc + LargPtr'(1);
      end
      if (w_pop) begin
        r_ptr_lei <= r_ptr_lei + LargPtr'(1);
      end
      if (w_escreve && !w_pop) begin
        r_contagem <= r_contagem + LargCont'(1);
      end else if (w_pop && !w_escreve) begin
        r_contagem <= r_contagem - LargCont'(1);
      end
      if (w_descarta && (r_descartes != '1)) begin
        r_descartes <= r_descartes + LARG_CONT'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible through the occupancy count.
  always_ff @(posedge clk) begin
    if (w_escreve) begin
      r_mem[r_ptr_esc] <= {overflow, w_valor};
    end
  end

  assign w_cabeca  = r_mem[r_ptr_lei];
  assign resultado = w_vazio ? 6'd0 : w_cabeca[5:0];
  assign ovf_out   = w_vazio ? 1'b0 : w_cabeca[6];
  assign valido    = ~w_vazio;
  assign vazio     = w_vazio;
  assign cheio     = w_cheio;
  assign contagem  = r_contagem;
  assign descartes = r_descartes;

endmodule

// File: tb/tb_captura_resultado_somador.sv
// Directed testbench for captura_resultado_somador (default depth 4, 8-bit
// discard counter). Expected values are hand-computed constants.
module tb_captura_resultado_somador;

  logic       clk;
  logic       reset;
  logic       pronto;
  logic [5:0] soma;
  logic       overflow;
  logic       rd_en;
  logic [5:0] resultado;
  logic       ovf_out;
  logic       valido;
  logic       vazio;
  logic       cheio;
  logic [2:0] contagem;
  logic [7:0] descartes;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef CAPTURA_SATURA_EN
  localparam logic [5:0] ExpSatNeg = 6'b011111;
  localparam logic [5:0] ExpSatPos = 6'b100000;
`else
  localparam logic [5:0] ExpSatNeg = 6'b110000;
  localparam logic [5:0] ExpSatPos = 6'b001010;
`endif

  captura_resultado_somador #(
    .PROFUNDIDADE(4),
    .LARG_CONT   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pronto   (pronto),
    .soma     (soma),
    .overflow (overflow),
    .rd_en    (rd_en),
    .resultado(resultado),
    .ovf_out  (ovf_out),
    .valido   (valido),
    .vazio    (vazio),
    .cheio    (cheio),
    .contagem (contagem),
    .descartes(descartes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop pronto for one sampled cycle, then raise it with the result present.
  task automatic captura(input logic [5:0] v, input logic ov, input logic pop);
    pronto = 1'b0;
    rd_en  = 1'b0;
    step();
    soma     = v;
    overflow = ov;
    pronto   = 1'b1;
    rd_en    = pop;
    step();
    rd_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    pronto   = 1'b1;
    soma     = '0;
    overflow = 1'b0;
    rd_en    = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // Idle-high pronto after reset must not capture.
    repeat (10) step();
    check_val("rst_vazio", vazio, 1);
    check_val("rst_valido", valido, 0);
    check_val("rst_cheio", cheio, 0);
    check_val("rst_contagem", contagem, 0);
    check_val("rst_descartes", descartes, 0);
    check_val("rst_resultado", resultado, 0);

    // Single capture, held-high pronto yields one entry, then pop.
    captura(6'd13, 1'b0, 1'b0);
    check_val("cap13_valido", valido, 1);
    check_val("cap13_resultado", resultado, 13);
    check_val("cap13_ovf", ovf_out, 0);
    check_val("cap13_contagem", contagem, 1);
    repeat (5) step();
    check_val("held_contagem", contagem, 1);
    pop();
    check_val("pop13_vazio", vazio, 1);
    check_val("pop13_resultado", resultado, 0);

    // Pop while empty is ignored.
    pop();
    check_val("pop_empty_contagem", contagem, 0);
    check_val("pop_empty_vazio", vazio, 1);

    // Five captures into depth 4: last one discarded.
    for (int i = 1; i <= 5; i++) captura(6'(i), 1'b0, 1'b0);
    check_val("fill_cheio", cheio, 1);
    check_val("fill_contagem", contagem, 4);
    check_val("fill_descartes", descartes, 1);
    for (int i = 1; i <= 4; i++) begin
      check_val($sformatf("drain_%0d", i), resultado, i);
      pop();
    end
    check_val("drain_vazio", vazio, 1);
    check_val("drain_contagem", contagem, 0);

    // Full FIFO, capture and pop on the same edge.
    for (int i = 1; i <= 4; i++) captura(6'(i), 1'b0, 1'b0);
    captura(6'd5, 1'b0, 1'b1);
    check_val("fullpop_contagem", contagem, 4);
    check_val("fullpop_descartes", descartes, 1);
    check_val("fullpop_head", resultado, 2);
    for (int i = 2; i <= 5; i++) begin
      check_val($sformatf("fullpop_drain_%0d", i), resultado, i);
      pop();
    end
    check_val("fullpop_vazio", vazio, 1);

    // Empty FIFO, capture and pop together: pop ignored, capture stored.
    captura(6'd21, 1'b0, 1'b1);
    check_val("emptypop_contagem", contagem, 1);
    check_val("emptypop_resultado", resultado, 21);
    pop();

    // Overflowed results: wrapped negative and wrapped positive.
    captura(6'b110000, 1'b1, 1'b0);
    captura(6'b001010, 1'b1, 1'b0);
    check_val("sat_neg_resultado", resultado, ExpSatNeg);
    check_val("sat_neg_ovf", ovf_out, 1);
    pop();
    check_val("sat_pos_resultado", resultado, ExpSatPos);
    check_val("sat_pos_ovf", ovf_out, 1);
    pop();
    check_val("sat_vazio", vazio, 1);

    // Asynchronous reset between edges with two entries stored.
    captura(6'd7, 1'b0, 1'b0);
    captura(6'd8, 1'b0, 1'b0);
    check_val("pre_rst_contagem", contagem, 2);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_contagem", contagem, 0);
    check_val("async_valido", valido, 0);
    check_val("async_resultado", resultado, 0);
    check_val("async_descartes", descartes, 0);
    #1;
    reset = 1'b1;
    step();
    check_val("post_rst_no_cap", contagem, 0);
    captura(6'd9, 1'b0, 1'b0);
    check_val("post_rst_resultado", resultado, 9);
    check_val("post_rst_contagem", contagem, 1);
    // Pointer restarted at slot 0: three more fill exactly to full, in order.
    for (int i = 10; i <= 12; i++) captura(6'(i), 1'b0, 1'b0);
    check_val("post_rst_cheio", cheio, 1);
    for (int i = 9; i <= 12; i++) begin
      check_val($sformatf("post_rst_drain_%0d", i), resultado, i);
      pop();
    end
    check_val("post_rst_vazio", vazio, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/captura_resultado_somador.md
# captura_resultado_somador

Downstream stage of the four-operand accumulator state machine. Detects each rising edge of the accumulator's `pronto` flag and captures the finished `soma`/`overflow` pair into a small show-ahead FIFO, so that results survive until a consumer (display driver or host read-out) pops them. Counts results discarded while the buffer is full.

## Interface
- `PROFUNDIDADE`, default 4: FIFO depth in entries; power of two, 2..16.
- `LARG_CONT`, default 8: width of the discard counter.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock, reset asynchronous and active-low.
- `pronto`  in  1  accumulator done flag; level signal, high while idle and at end of a sum.
- `soma`  in  6  accumulator result, two's complement.
- `overflow`  in  1  accumulator signed-overflow flag, valid with `soma`.
- `rd_en`  in  1  pop request for the head entry.
- `resultado`  out  6  head entry value; 0 when empty.
- `ovf_out`  out  1  head entry overflow flag; 0 when empty.
- `valido`  out  1  head entry present (equals not `vazio`).
- `vazio`  out  1  FIFO empty.
- `cheio`  out  1  FIFO full.
- `contagem`  out  $clog2(PROFUNDIDADE)+1  number of stored entries.
- `descartes`  out  LARG_CONT  results lost because FIFO was full; saturates at all-ones.

## Operation
- Edge detector: register `pronto_d` samples `pronto` every cycle; capture event `cap = pronto & ~pronto_d`.
- `pronto_d` resets to 1, so the idle-high `pronto` after reset produces no capture.
- On `cap`: entry {`overflow`, value} written at write pointer, where value is `soma` (or saturated value, see Configuration), sampled at the same edge.
- Pop: `rd_en & ~vazio` advances read pointer; `rd_en` while empty is ignored, no error state.
- Pointers wrap modulo `PROFUNDIDADE`; `contagem` tracks occupancy, `cheio` = (`contagem` == `PROFUNDIDADE`), `vazio` = (`contagem` == 0).
- Simultaneous cap and pop:
  - not empty, not full: both happen, `contagem` unchanged.
  - full: pop frees slot, capture accepted, no discard.
  - empty: no bypass; pop ignored, capture stored, `contagem` = 1.
- Capture while full without pop: entry dropped, FIFO unchanged, `descartes` += 1 unless saturated.
- Outputs `resultado`/`ovf_out` are show-ahead: they always reflect the head entry; forced to 0 when empty.

## Timing
- Reset (`reset` low, asynchronous): pointers 0, `contagem` 0, `vazio` 1, `cheio` 0, `valido` 0, `resultado` 0, `ovf_out` 0, `descartes` 0, `pronto_d` 1. Storage array contents irrelevant.
- Reset release is registered on next rising edge of `clk`; reset asserted mid-operation discards all stored entries immediately.
- Capture latency: edge where `pronto`=1 and `pronto_d`=0 writes; `valido`/`resultado` update 1 cycle later (visible after that edge).
- Pop latency: after the edge sampling `rd_en`=1, next entry appears on outputs in the same following cycle; back-to-back pops every cycle allowed.
- `pronto` held high for many cycles yields exactly one capture; minimum spacing between captures is 2 cycles (`pronto` must drop for ≥1 sampled cycle).

## Configuration
- `CAPTURA_SATURA_EN` defined: when `overflow`=1 at capture, stored value saturates: `soma[5]`=1 (wrapped negative) stores 6'b011111 (+31); `soma[5]`=0 stores 6'b100000 (−32). `ovf_out` still stored as 1.
- Not defined: `soma` stored unmodified regardless of `overflow`.

## Test plan
- Reset with `pronto`=1 held 10 cycles -> no capture, `vazio`=1, `contagem`=0, `descartes`=0.
- `pronto` 0→1 with `soma`=6'd13, `overflow`=0 -> next cycle `valido`=1, `resultado`=13, `contagem`=1; `rd_en` pulse -> `vazio`=1, `resultado`=0.
- Five captures (values 1,2,3,4,5) without pops, depth 4 -> `cheio`=1, `descartes`=1; pops return 1,2,3,4 in order then `vazio`.
- Full FIFO, capture and `rd_en` same edge -> `contagem` stays 4, `descartes` unchanged, head advances, value 5 last out.
- `soma`=6'b110000, `overflow`=1 -> with `CAPTURA_SATURA_EN` `resultado`=6'b011111, `ovf_out`=1; without it `resultado`=6'b110000, `ovf_out`=1.
- Two entries stored, `reset` pulsed low asynchronously between clock edges -> outputs zero immediately, `contagem`=0, later capture lands at slot 0.
